// File: rtl/mul_share_pkg.sv
// ---------------------------------------------------------------------------
// Module : mul_share_pkg
// Brief  : Shared types, constants and the rotating-priority pick function
//          for the shared approximate multiplier arbiter.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package mul_share_pkg;

    localparam int IN_W        = 16;
    localparam int PROD_W      = 32;
    localparam int SHIFT_W_DEF = 8;
    localparam int MAX_REQ     = 8;
    localparam int MAX_ID_W    = 3;

    typedef struct packed {
        logic signed [IN_W-1:0]   a;
        logic signed [IN_W-1:0]   b;
        logic [MAX_ID_W-1:0]      id;
    } req_t;

    typedef struct packed {
        logic signed [PROD_W-1:0] data;
        logic [MAX_ID_W-1:0]      id;
    } resp_t;

    typedef struct packed {
        logic                     found;
        logic [MAX_ID_W-1:0]      idx;
    } pick_t;

    // First valid requester at or after ptr, wrapping modulo n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                      input logic [MAX_ID_W-1:0] ptr,
                                      input int                  n);
        pick_t r;
        int    k;
        r = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n && !r.found) begin
                k = (int'(ptr) + i) % n;
                if (valid[k]) begin
                    r.found = 1'b1;
                    r.idx   = MAX_ID_W'(k);
                end
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mul_ex_12bit.sv
// ---------------------------------------------------------------------------
// Module : mul_ex_12bit
// Brief  : Approximate signed 16x16 multiplier keeping the 12 most
//          significant magnitude bits of each operand.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mul_ex_12bit (
    input  logic signed [15:0] i_a,
    input  logic signed [15:0] i_b,
    output logic signed [31:0] o_p
);

    logic signed [16:0] w_ext_a;
    logic signed [16:0] w_ext_b;
    logic [16:0]        w_mag_a;
    logic [16:0]        w_mag_b;
    logic [31:0]        w_mag_p;
    logic               w_neg;

    // 17-bit magnitudes so that -32768 is representable before truncation.
    assign w_ext_a = {i_a[15], i_a};
    assign w_ext_b = {i_b[15], i_b};
    assign w_mag_a = (i_a[15] ? -w_ext_a : w_ext_a) & 17'h1FFF0;
    assign w_mag_b = (i_b[15] ? -w_ext_b : w_ext_b) & 17'h1FFF0;
    assign w_mag_p = 32'(w_mag_a) * 32'(w_mag_b);
    assign w_neg   = i_a[15] ^ i_b[15];
    assign o_p     = w_neg ? -w_mag_p : w_mag_p;

endmodule

`default_nettype wire

// File: rtl/mul_share_arb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// Module : rr_arbiter
// Brief  : N-wide rotating-priority grant with pointer advance on grant.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i_valid,
    input  logic             i_enable,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_found,
    output logic [ID_W-1:0]  o_idx
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    pick_t           pick;
    logic            w_unused_idx;

    always_comb begin
        pick    = rr_pick(MAX_REQ'(i_valid), MAX_ID_W'(ptr_q), N_REQ);
        o_found = pick.found;
        o_idx   = pick.idx[ID_W-1:0];
        o_grant = '0;
        ptr_d   = ptr_q;
        if (i_enable && pick.found) begin
            o_grant[o_idx] = 1'b1;
            ptr_d          = ID_W'((int'(pick.idx) + 1) % N_REQ);
        end
    end

    assign w_unused_idx = ^pick.idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mul_share_arb.sv
// ---------------------------------------------------------------------------
// Module : mul_share_arb
// Brief  : Round-robin sharing of one mul_ex_12bit across N_REQ requesters,
//          two-stage pipeline with a single tagged, rescaled response channel.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int IN_W    = 16,
    parameter int SHIFT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*IN_W-1:0]   req_a,
    input  logic [N_REQ*IN_W-1:0]   req_b,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [31:0]             resp_data,
    output logic                    busy
);

    req_t               s1_q, s1_d;
    resp_t              s2_q, s2_d;
    logic               v1_q, v1_d;
    logic               v2_q, v2_d;
    logic               w_stall;
    logic               w_adv;
    logic               w_found;
    logic [ID_W-1:0]    w_idx;
    logic signed [31:0] w_product;
    logic signed [31:0] w_scaled;
    logic               w_unused_id;

    assign w_stall = v2_q & ~resp_ready;
    assign w_adv   = ~w_stall & ~rst;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (req_valid),
        .i_enable (w_adv),
        .o_grant  (req_ready),
        .o_found  (w_found),
        .o_idx    (w_idx)
    );

    mul_ex_12bit u_mul (
        .i_a (s1_q.a),
        .i_b (s1_q.b),
        .o_p (w_product)
    );

    assign w_scaled = w_product >>> SHIFT_W;

    // Both stages advance together; a stall freezes S1, S2 and the pointer.
    always_comb begin
        v1_d = v1_q;
        s1_d = s1_q;
        v2_d = v2_q;
        s2_d = s2_q;
        if (!w_stall) begin
            v1_d = w_found;
            if (w_found) begin
                s1_d.a  = req_a[w_idx*IN_W +: IN_W];
                s1_d.b  = req_b[w_idx*IN_W +: IN_W];
                s1_d.id = MAX_ID_W'(w_idx);
            end
            v2_d = v1_q;
            if (v1_q) begin
                s2_d.data = w_scaled;
                s2_d.id   = s1_q.id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign resp_valid  = v2_q;
    assign resp_id     = s2_q.id[ID_W-1:0];
    assign resp_data   = s2_q.data;
    assign busy        = v1_q | v2_q;
    assign w_unused_id = ^s2_q.id;

endmodule

`default_nettype wire
